aftab_csr_access_ctrl: RTL

Sequencer for all CSR accesses in the AFTAB interrupt datapath. It accepts Zicsr instructions (CSRRW/RS/RC and immediate forms) from the main controller and checks the CSR address. It then drives the CSR register bank through fixed read, modify and write phases, or raises an illegal-instruction trap. It also arbitrates the CSR bank between the instruction path and the interrupt unit, which must update mstatus/mepc/mcause/mip atomically.

---
 rtl/aftab_csr_access_ctrl_pkg.sv | 31 +++
 rtl/aftab_csr_access_ctrl_if.sv | 27 ++
 rtl/aftab_csr_addr_check.sv | 23 ++
 rtl/aftab_csr_access_ctrl.sv | 76 +++++++
 4 files changed

// File: rtl/aftab_csr_access_ctrl_pkg.sv
// aftab_csr_access_ctrl_pkg: shared state encoding, operand/op encodings and CSR address map
package aftab_csr_access_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_INT, S_CHECK, S_READ, S_MODIFY, S_WRITE, S_DONE, S_TRAP
  } csr_state_e;
  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_SET  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MEDELEG  = 12'h302;
  localparam logic [11:0] CSR_MIDELEG  = 12'h303;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_USTATUS  = 12'h000;
  localparam logic [11:0] CSR_UIE      = 12'h004;
  localparam logic [11:0] CSR_UTVEC    = 12'h005;
  localparam logic [11:0] CSR_UEPC     = 12'h041;
  localparam logic [11:0] CSR_UCAUSE   = 12'h042;
  localparam logic [11:0] CSR_UTVAL    = 12'h043;
  localparam logic [11:0] CSR_UIP      = 12'h044;
endpackage

// File: rtl/aftab_csr_access_ctrl_if.sv
// aftab_csr_access_ctrl_if: instruction-path request, interrupt arbitration and CSR bank strobes
// master = main controller / interrupt unit / CSR bank side, slave = access sequencer
interface aftab_csr_access_ctrl_if #(parameter int ADDR_W = 12);
  logic              csrStart;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] csrAddr;
  logic              rs1Zero;
  logic              rdZero;
  logic              intReq;
  logic              intGnt;
  logic              csrRdEn;
  logic              ldRd;
  logic [1:0]        csrOpSel;
  logic              csrSrcImm;
  logic              csrWrEn;
  logic              csrDone;
  logic              illegalInstr;
  logic              csrBusy;
  modport master (
    output csrStart, funct3, csrAddr, rs1Zero, rdZero, intReq,
    input  intGnt, csrRdEn, ldRd, csrOpSel, csrSrcImm, csrWrEn, csrDone, illegalInstr, csrBusy
  );
  modport slave (
    input  csrStart, funct3, csrAddr, rs1Zero, rdZero, intReq,
    output intGnt, csrRdEn, ldRd, csrOpSel, csrSrcImm, csrWrEn, csrDone, illegalInstr, csrBusy
  );
endinterface

// File: rtl/aftab_csr_addr_check.sv
// aftab_csr_addr_check: combinational CSR address validity
// addr_i: CSR address, valid_o: address implemented; user CSRs only with AFTAB_CSR_USER_MODE_EN
module aftab_csr_addr_check import aftab_csr_access_ctrl_pkg::*; #(
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o
);
  logic valid_m, valid_u;
  always_comb begin
    valid_m = addr_i inside {ADDR_W'(CSR_MSTATUS), ADDR_W'(CSR_MEDELEG), ADDR_W'(CSR_MIDELEG),
                             ADDR_W'(CSR_MIE), ADDR_W'(CSR_MTVEC), ADDR_W'(CSR_MEPC),
                             ADDR_W'(CSR_MCAUSE), ADDR_W'(CSR_MTVAL), ADDR_W'(CSR_MIP)};
`ifdef AFTAB_CSR_USER_MODE_EN
    valid_u = addr_i inside {ADDR_W'(CSR_USTATUS), ADDR_W'(CSR_UIE), ADDR_W'(CSR_UTVEC),
                             ADDR_W'(CSR_UEPC), ADDR_W'(CSR_UCAUSE), ADDR_W'(CSR_UTVAL),
                             ADDR_W'(CSR_UIP)};
`else
    valid_u = 1'b0;
`endif
    valid_o = valid_m || valid_u;
  end
endmodule

// File: rtl/aftab_csr_access_ctrl.sv
// aftab_csr_access_ctrl: sequences Zicsr accesses to the CSR bank and arbitrates it with the interrupt unit
// clk, rst (async, active-low); bus: slave side of aftab_csr_access_ctrl_if
// Optional AFTAB_CSR_USER_MODE_EN (in aftab_csr_addr_check) adds the user CSRs to the legal set.
module aftab_csr_access_ctrl import aftab_csr_access_ctrl_pkg::*; #(
  parameter int ADDR_W = 12
) (
  input logic                   clk,
  input logic                   rst,
  aftab_csr_access_ctrl_if.slave bus
);
  csr_state_e        state_q, state_d;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rs1_zero_q, rd_zero_q;
  logic              int_gnt_q, rd_en_q, ld_rd_q, imm_q, wr_en_q, done_q, ill_q, busy_q;
  logic [1:0]        op_q;
  logic              addr_ok, legal, rw, mod_wr;
  aftab_csr_addr_check #(.ADDR_W(ADDR_W)) u_addr_check (.addr_i(addr_q), .valid_o(addr_ok));
  always_comb begin
    legal   = addr_ok && f3_q[1:0] != 2'b00;
    rw      = f3_q[1:0] == F3_CSRRW[1:0];
    state_d = state_q == S_IDLE   ? (bus.intReq ? S_INT : bus.csrStart ? S_CHECK : S_IDLE)
            : state_q == S_INT    ? (bus.intReq ? S_INT : S_IDLE)
            : state_q == S_CHECK  ? (legal ? S_READ : S_TRAP)
            : state_q == S_READ   ? S_MODIFY
            : state_q == S_MODIFY ? S_WRITE
            : state_q == S_WRITE  ? S_DONE
            : S_IDLE;
    mod_wr  = state_d inside {S_MODIFY, S_WRITE};
  end
  // outputs are registered from the next state so each strobe lines up with its phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      f3_q       <= '0;
      addr_q     <= '0;
      rs1_zero_q <= 1'b0;
      rd_zero_q  <= 1'b0;
      int_gnt_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      ld_rd_q    <= 1'b0;
      op_q       <= OP_PASS;
      imm_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      ill_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && !bus.intReq && bus.csrStart) begin
        f3_q       <= bus.funct3;
        addr_q     <= bus.csrAddr;
        rs1_zero_q <= bus.rs1Zero;
        rd_zero_q  <= bus.rdZero;
      end
      int_gnt_q <= state_d == S_INT;
      busy_q    <= state_d != S_IDLE;
      rd_en_q   <= state_d == S_READ && !(rw && rd_zero_q);
      ld_rd_q   <= state_d == S_MODIFY && !rd_zero_q;
      op_q      <= mod_wr ? f3_q[1:0] - 2'd1 : OP_PASS;
      imm_q     <= mod_wr && f3_q[2];
      wr_en_q   <= state_d == S_WRITE && (rw || !rs1_zero_q);
      done_q    <= state_d == S_DONE;
      ill_q     <= state_d == S_TRAP;
    end
  end
  assign bus.intGnt       = int_gnt_q;
  assign bus.csrRdEn      = rd_en_q;
  assign bus.ldRd         = ld_rd_q;
  assign bus.csrOpSel     = op_q;
  assign bus.csrSrcImm    = imm_q;
  assign bus.csrWrEn      = wr_en_q;
  assign bus.csrDone      = done_q;
  assign bus.illegalInstr = ill_q;
  assign bus.csrBusy      = busy_q;
endmodule
